// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - shared state encoding and default counter width for the XOR frame checker
package xor_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/popcount4.sv
// rtl/popcount4.sv - combinational set-bit count of a 4-bit beat
module popcount4 (
  input  logic [3:0] a,
  output logic [2:0] cnt
);

  assign cnt = {2'b00, a[0]} + {2'b00, a[1]} + {2'b00, a[2]} + {2'b00, a[3]};

endmodule

// File: rtl/xor_frame_checker.sv
// rtl/xor_frame_checker.sv - folds a frame of 4-bit XOR beats into a checksum,
// a saturating set-bit count and a saturating beat count, then offers one summary.
module xor_frame_checker
  import xor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_chk,
  output logic [CNT_W-1:0] out_errcnt,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       chk_q, chk_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             sat_q, sat_d;

  logic [2:0]       beat_pop;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W:0]   beat_sum;
  logic             accept;

  popcount4 u_popcount4 (
    .a   (in_y),
    .cnt (beat_pop)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // One extra bit on each sum exposes the carry that signals a clipped addition.
  assign err_sum  = {1'b0, errcnt_q} + {{(CNT_W - 2){1'b0}}, beat_pop};
  assign beat_sum = {1'b0, beats_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    errcnt_d = errcnt_q;
    beats_d  = beats_q;
    sat_d    = sat_q;

    if (accept) begin
      chk_d    = chk_q ^ in_y;
      errcnt_d = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
      beats_d  = beat_sum[CNT_W] ? CNT_MAX : beat_sum[CNT_W-1:0];
      sat_d    = sat_q | err_sum[CNT_W] | beat_sum[CNT_W];
    end

    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          chk_d    = '0;
          errcnt_d = '0;
          beats_d  = '0;
          sat_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chk_q    <= '0;
      errcnt_q <= '0;
      beats_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chk_q    <= chk_d;
      errcnt_q <= errcnt_d;
      beats_q  <= beats_d;
      sat_q    <= sat_d;
    end
  end

  assign out_chk    = chk_q;
  assign out_errcnt = errcnt_q;
  assign out_beats  = beats_q;
  assign out_sat    = sat_q;

endmodule
